// File: rtl/stereo_pkg.sv
// rtl/stereo_pkg.sv - shared widths, latency and masked-cost helpers for the stereo matcher
package stereo_pkg;

    function automatic int disp_width(input int d);
        return $clog2(d);
    endfunction

    function automatic int cost_width(input int cw);
        return $clog2(cw + 1);
    endfunction

    // Sampling edge to o_dval edge: stage 1, stage 2, then one level per min-tree layer.
    function automatic int pipe_latency(input int d);
        return 2 + $clog2(d);
    endfunction

    function automatic int masked_cost(input int csw);
        return (1 << csw) - 1;
    endfunction

endpackage

// File: rtl/census_popcount.sv
// rtl/census_popcount.sv - combinational population count of one census XOR vector
module census_popcount
    import stereo_pkg::*;
#(
    parameter int CW  = 8,
    parameter int CSW = cost_width(CW)
) (
    input  logic [CW-1:0]  i_data,
    output logic [CSW-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < CW; i++) begin
            o_count = o_count + CSW'(i_data[i]);
        end
    end

endmodule

// File: rtl/census_cost_wta.sv
// rtl/census_cost_wta.sv - Hamming matching cost over D disparities with winner-take-all select
module census_cost_wta
    import stereo_pkg::*;
#(
    parameter  int CW  = 8,
    parameter  int D   = 16,
    parameter  int M   = 50,
    localparam int DW  = disp_width(D),
    localparam int CSW = cost_width(CW)
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic [CW-1:0]  i_left,
    input  logic [CW-1:0]  i_right,
    input  logic           i_dval,
    output logic           o_dval,
    output logic [DW-1:0]  o_disp,
    output logic [CSW-1:0] o_cost
);

    localparam int             L         = pipe_latency(D);
    localparam int             CLW       = (M > 1) ? $clog2(M) : 1;
    localparam logic [CSW-1:0] MASK_COST = CSW'(masked_cost(CSW));

    logic [CW-1:0]  hist_q [D-1];
    logic [CLW-1:0] col_q;
    logic [L-1:0]   vld_q;
    logic           o_dval_q;
    logic [CW-1:0]  w [D];
    logic [CW-1:0]  x_q [D];
    logic [D-1:0]   v_q;
    logic [CSW-1:0] pc [D];
    logic [CSW-1:0] leaf_cost_q [D];
    logic [CSW-1:0] node_cost [1:D-1];
    logic [DW-1:0]  node_idx [1:D-1];

    always_comb begin
        w[0] = i_right;
        for (int d = 1; d < D; d++) begin
            w[d] = hist_q[d-1];
        end
    end

    // Stage 1: history, column and XOR/mask capture advance only on accepted pixels.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            col_q <= '0;
            v_q   <= '0;
            for (int d = 0; d < D; d++)     x_q[d]    <= '0;
            for (int k = 0; k < D - 1; k++) hist_q[k] <= '0;
        end else if (i_dval) begin
            hist_q[0] <= i_right;
            for (int k = 1; k < D - 1; k++) hist_q[k] <= hist_q[k-1];
            col_q <= (col_q == CLW'(M - 1)) ? '0 : col_q + 1'b1;
            for (int d = 0; d < D; d++) begin
                x_q[d] <= i_left ^ w[d];
                v_q[d] <= (d > int'(col_q));
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            vld_q    <= '0;
            o_dval_q <= 1'b0;
        end else begin
            vld_q    <= {vld_q[L-2:0], i_dval};
            o_dval_q <= vld_q[L-1];
        end
    end

    for (genvar d = 0; d < D; d++) begin : g_pc
        census_popcount #(.CW(CW), .CSW(CSW)) u_popcount (
            .i_data  (x_q[d]),
            .o_count (pc[d])
        );
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int d = 0; d < D; d++) leaf_cost_q[d] <= '0;
        end else begin
            for (int d = 0; d < D; d++) leaf_cost_q[d] <= v_q[d] ? MASK_COST : pc[d];
        end
    end

    // Heap-ordered min tree: node n has children 2n and 2n+1, leaves sit at D..2D-1.
    // The left child always covers lower disparities, so it keeps ties.
    for (genvar n = 1; n < D; n++) begin : g_node
        logic [CSW-1:0] lc, rc, cost_q;
        logic [DW-1:0]  li, ri, idx_q;

        if (2 * n >= D) begin : g_leaf
            assign lc = leaf_cost_q[2*n-D];
            assign rc = leaf_cost_q[2*n+1-D];
            assign li = DW'(2 * n - D);
            assign ri = DW'(2 * n + 1 - D);
        end else begin : g_inner
            assign lc = node_cost[2*n];
            assign rc = node_cost[2*n+1];
            assign li = node_idx[2*n];
            assign ri = node_idx[2*n+1];
        end

        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                cost_q <= '0;
                idx_q  <= '0;
            end else if (rc < lc) begin
                cost_q <= rc;
                idx_q  <= ri;
            end else begin
                cost_q <= lc;
                idx_q  <= li;
            end
        end

        assign node_cost[n] = cost_q;
        assign node_idx[n]  = idx_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_disp <= '0;
            o_cost <= '0;
        end else if (vld_q[L-1]) begin
            o_disp <= node_idx[1];
            o_cost <= node_cost[1];
        end
    end

    assign o_dval = o_dval_q;

endmodule

// File: tb/tb_census_cost_wta.sv
// tb/tb_census_cost_wta.sv - directed and random checks of census_cost_wta against a reference model
module tb_census_cost_wta;

    localparam int CW = 8;
    localparam int D  = 4;
    localparam int M  = 8;
    localparam int L  = 4;

    logic       i_clk  = 1'b0;
    logic       i_rstn = 1'b1;
    logic       i_dval = 1'b0;
    logic [7:0] i_left = '0;
    logic [7:0] i_right = '0;
    logic       o_dval;
    logic [1:0] o_disp;
    logic [3:0] o_cost;

    census_cost_wta #(.CW(CW), .D(D), .M(M)) dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_left  (i_left),
        .i_right (i_right),
        .i_dval  (i_dval),
        .o_dval  (o_dval),
        .o_disp  (o_disp),
        .o_cost  (o_cost)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int due;
        int disp;
        int cost;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] rh[$];
    int         mcol;
    int         cyc;
    int         n_chk;
    int         n_pass;
    int         last_disp;
    int         last_cost;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: best candidate over all disparities not further left than the line start.
    task automatic model_push(input logic [7:0] l, input logic [7:0] r);
        int         best_c;
        int         best_d;
        int         c;
        logic [7:0] wv;
        best_c = 1000;
        best_d = 0;
        for (int d = 0; d < D; d++) begin
            if (d <= mcol) begin
                wv = (d == 0) ? r : rh[d-1];
                c  = $countones(l ^ wv);
                if (c < best_c) begin
                    best_c = c;
                    best_d = d;
                end
            end
        end
        expq.push_back('{cyc + 1 + L, best_d, best_c});
        rh.push_front(r);
        if (rh.size() > D) void'(rh.pop_back());
        mcol = (mcol + 1) % M;
    endtask

    task automatic check_out();
        if (expq.size() > 0 && expq[0].due == cyc) begin
            chk("o_dval", o_dval, 1);
            chk("o_disp", o_disp, expq[0].disp);
            chk("o_cost", o_cost, expq[0].cost);
            last_disp = expq[0].disp;
            last_cost = expq[0].cost;
            void'(expq.pop_front());
        end else begin
            chk("o_dval_idle", o_dval, 0);
            chk("o_disp_hold", o_disp, last_disp);
            chk("o_cost_hold", o_cost, last_cost);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] l, input logic [7:0] r);
        i_dval  = v;
        i_left  = l;
        i_right = r;
        if (v) model_push(l, r);
        @(posedge i_clk);
        #1;
        cyc++;
        check_out();
    endtask

    task automatic do_reset();
        i_dval = 1'b0;
        i_rstn = 1'b0;
        #1;
        chk("rst_o_dval", o_dval, 0);
        chk("rst_o_disp", o_disp, 0);
        chk("rst_o_cost", o_cost, 0);
        expq.delete();
        rh.delete();
        mcol      = 0;
        last_disp = 0;
        last_cost = 0;
        @(posedge i_clk);
        #1;
        cyc++;
        chk("rst_hold_o_dval", o_dval, 0);
        i_rstn = 1'b1;
    endtask

    task automatic random_steps(input int n);
        logic       v;
        logic [7:0] l;
        for (int i = 0; i < n; i++) begin
            v = ($urandom_range(3) != 0);
            if ($urandom_range(1) == 1 && rh.size() >= D)
                l = rh[$urandom_range(D - 1)] ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            else
                l = 8'($urandom);
            step(v, l, 8'($urandom));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] rs [8];
        logic       pat [7];
        n_chk  = 0;
        n_pass = 0;
        cyc    = 0;
        mcol   = 0;
        #2;
        do_reset();

        for (int x = 0; x < 8; x++) step(1'b1, 8'hA5, 8'hA5);

        for (int x = 0; x < 8; x++) rs[x] = 8'h01 << x;
        for (int x = 0; x < 8; x++) step(1'b1, (x >= 2) ? rs[x-2] : 8'h3C, rs[x]);

        for (int x = 0; x < 8; x++) step(1'b1, 8'h00, 8'hFF);

        step(1'b1, 8'h0F, 8'h1F);
        step(1'b1, 8'h0F, 8'hF0);
        step(1'b1, 8'h0F, 8'h0E);
        step(1'b1, 8'h0F, 8'h00);
        for (int x = 0; x < 4; x++) step(1'b1, 8'($urandom), 8'($urandom));

        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) step(pat[i], 8'($urandom), 8'($urandom));
        for (int i = 0; i < L + 1; i++) step(1'b0, 8'($urandom), 8'($urandom));

        random_steps(200);

        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 8'($urandom));
        do_reset();
        for (int i = 0; i < L + 2; i++) step(1'b0, 8'($urandom), 8'($urandom));
        random_steps(40);
        for (int i = 0; i < L + 2; i++) step(1'b0, 8'($urandom), 8'($urandom));

        chk("queue_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
